// File: rtl/regfile_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// regfile_pkg : shared state encoding and default sizes for regfile_mp
// Rev 1.0
// ---------------------------------------------------------------------------
package regfile_pkg;

  localparam int          DATA_W_DEF   = 32;
  localparam int          ADDR_W_DEF   = 6;
  localparam logic [31:0] INIT_VAL_DEF = 32'h0000_0002;

  typedef enum logic [0:0] {
    INIT  = 1'b0,
    READY = 1'b1
  } state_e;

endpackage : regfile_pkg
`default_nettype wire

// File: rtl/regfile_init_seq.sv
`default_nettype none
// ---------------------------------------------------------------------------
// regfile_init_seq : INIT/READY FSM and sweep index for the register file
// Rev 1.0
// ---------------------------------------------------------------------------
module regfile_init_seq
  import regfile_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            init_req,
  output logic [ADDR_W:0] idx,
  output logic            sweep_we,
  output logic            ready
);

  // One spare MSB keeps the last-entry compare free of wrap-around.
  localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'((2**ADDR_W) - 1);
  localparam logic [ADDR_W:0] IDX_ONE  = (ADDR_W+1)'(1);

  state_e          state_q, state_d;
  logic [ADDR_W:0] idx_q, idx_d;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      INIT: begin
        if (idx_q == LAST_IDX) begin
          state_d = READY;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + IDX_ONE;
        end
      end
      READY: begin
        if (init_req) begin
          state_d = INIT;
          idx_d   = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= INIT;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  assign idx      = idx_q;
  assign sweep_we = (state_q == INIT);
  assign ready    = (state_q == READY);

endmodule : regfile_init_seq
`default_nettype wire

// File: rtl/regfile_mp.sv
`default_nettype none
// ---------------------------------------------------------------------------
// regfile_mp : multi-read-port register file with power-up init sweep
// Optional same-cycle write forwarding: define REGFILE_BYPASS_EN.  Rev 1.0
// ---------------------------------------------------------------------------
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int                DATA_W   = DATA_W_DEF,
  parameter int                ADDR_W   = ADDR_W_DEF,
  parameter int                NUM_RD   = 2,
  parameter int                INIT_CNT = 2,
  parameter logic [DATA_W-1:0] INIT_VAL = DATA_W'(INIT_VAL_DEF)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     init_req,
  output logic                     ready,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  output logic                     wr_drop
);

  localparam int              DEPTH      = 2**ADDR_W;
  localparam logic [ADDR_W:0] INIT_CNT_W = (ADDR_W+1)'(INIT_CNT);

  logic [ADDR_W:0]   idx;
  logic              sweep_we;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic              wr_drop_q, wr_drop_d;
  logic [DATA_W-1:0] mem_q [DEPTH];

  regfile_init_seq #(
    .ADDR_W (ADDR_W)
  ) u_init_seq (
    .clk      (clk),
    .rst_n    (rst_n),
    .init_req (init_req),
    .idx      (idx),
    .sweep_we (sweep_we),
    .ready    (ready)
  );

  // The sweep owns the write port while it runs; user writes are dropped.
  always_comb begin
    mem_we    = sweep_we | (ready & wr_en);
    mem_waddr = wr_addr;
    mem_wdata = wr_data;
    if (sweep_we) begin
      mem_waddr = idx[ADDR_W-1:0];
      mem_wdata = (idx < INIT_CNT_W) ? INIT_VAL : '0;
    end
    wr_drop_d = wr_en & ~ready;
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_drop_q <= 1'b0;
    end else begin
      wr_drop_q <= wr_drop_d;
    end
  end

  assign wr_drop = wr_drop_q;

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] raddr;
    logic              fwd;

    assign raddr = rd_addr[k*ADDR_W +: ADDR_W];
`ifdef REGFILE_BYPASS_EN
    assign fwd = ready & wr_en & (wr_addr == raddr);
`else
    assign fwd = 1'b0;
`endif
    assign rd_data[k*DATA_W +: DATA_W] = !ready ? '0 : (fwd ? wr_data : mem_q[raddr]);
  end

endmodule : regfile_mp
`default_nettype wire

// File: tb/tb_regfile_mp.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_regfile_mp : scoreboard bench for regfile_mp (default parameters)
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_regfile_mp;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 6;
  localparam int NUM_RD = 2;
  localparam int DEPTH  = 64;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic                     init_req;
  logic                     ready;
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic                     wr_en;
  logic [ADDR_W-1:0]        wr_addr;
  logic [DATA_W-1:0]        wr_data;
  logic                     wr_drop;

  regfile_mp #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .NUM_RD   (NUM_RD),
    .INIT_CNT (2),
    .INIT_VAL (32'h0000_0002)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .init_req (init_req),
    .ready    (ready),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_drop  (wr_drop)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    int          port;
    logic [31:0] exp;
  } sb_t;

  sb_t         sb_q[$];
  logic [31:0] model [DEPTH];
  int          n_checks = 0;
  int          n_errs   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_sweep();
    for (int i = 0; i < DEPTH; i++) model[i] = (i < 2) ? 32'h2 : 32'h0;
  endtask

  task automatic sb_drain();
    sb_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_eq(e.tag, 64'(rd_data[e.port*DATA_W +: DATA_W]), 64'(e.exp));
    end
  endtask

  task automatic rd_pair(input string tag, input logic [5:0] a0, input logic [5:0] a1);
    @(negedge clk);
    rd_addr = {a1, a0};
    sb_q.push_back('{tag: {tag, "_p0"}, port: 0, exp: model[a0]});
    sb_q.push_back('{tag: {tag, "_p1"}, port: 1, exp: model[a1]});
    #2;
    sb_drain();
  endtask

  task automatic wr(input logic [5:0] a, input logic [31:0] d);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    @(negedge clk);
    wr_en    = 1'b0;
    model[a] = d;
    check_eq("wr_no_drop", 64'(wr_drop), 64'd0);
  endtask

  // Entered just after a negedge; returns the number of edges until ready rises.
  task automatic sweep(input int drop_cyc, input logic [5:0] drop_addr, input int req_cyc,
                       input int rst_cyc, output int n);
    int rc;
    rc = rst_cyc;
    n  = 0;
    for (int guard = 0; guard < 300; guard++) begin
      if (drop_cyc >= 0 && n == drop_cyc + 1) check_eq("drop_pulse", 64'(wr_drop), 64'd1);
      if (drop_cyc >= 0 && n == drop_cyc + 2) check_eq("drop_clear", 64'(wr_drop), 64'd0);
      if (n == 5) check_eq("rd_zero_init", 64'(rd_data), 64'd0);
      if (n == rc) begin
        #2 rst_n = 1'b0;
        #1;
        check_eq("mid_rst_ready", 64'(ready), 64'd0);
        check_eq("mid_rst_drop", 64'(wr_drop), 64'd0);
        wr_en    = 1'b0;
        init_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        rc    = -1;
        n     = 0;
      end
      wr_en    = (n == drop_cyc);
      wr_addr  = drop_addr;
      wr_data  = 32'hBAD0_0000 | 32'(n);
      init_req = (n == req_cyc);
      @(posedge clk);
      n++;
      #1;
      if (ready) break;
      @(negedge clk);
    end
    wr_en    = 1'b0;
    init_req = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int n;
    rst_n    = 1'b0;
    init_req = 1'b0;
    wr_en    = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    rd_addr  = '0;
    #3;
    check_eq("rst_ready", 64'(ready), 64'd0);
    check_eq("rst_drop", 64'(wr_drop), 64'd0);
    check_eq("rst_rd_zero", 64'(rd_data), 64'd0);

    // Power-up sweep with a dropped write at cycle 10 and an ignored init_req.
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    sweep(10, 6'd40, 20, -1, n);
    check_eq("sweep0_edges", 64'(n), 64'd64);
    model_sweep();
    rd_pair("init01", 6'd0, 6'd1);
    rd_pair("init2_63", 6'd2, 6'd63);
    rd_pair("drop40", 6'd40, 6'd39);

    wr(6'd5, 32'hDEAD_BEEF);
    rd_pair("wr5", 6'd5, 6'd5);

    // Same-cycle write/read of address 7.
    @(negedge clk);
    wr_en   = 1'b1;
    wr_addr = 6'd7;
    wr_data = 32'h0000_1234;
    rd_addr = {6'd5, 6'd7};
`ifdef REGFILE_BYPASS_EN
    sb_q.push_back('{tag: "byp_p0", port: 0, exp: 32'h0000_1234});
`else
    sb_q.push_back('{tag: "byp_p0", port: 0, exp: model[7]});
`endif
    sb_q.push_back('{tag: "byp_p1", port: 1, exp: model[5]});
    #2;
    sb_drain();
    @(negedge clk);
    wr_en    = 1'b0;
    model[7] = 32'h0000_1234;
    rd_pair("wr7", 6'd7, 6'd7);

    // Re-init from READY with a same-cycle write, then a dropped write behind the sweep.
    wr(6'd1, 32'h0000_00AA);
    rd_pair("wr1", 6'd1, 6'd63);
    @(negedge clk);
    init_req = 1'b1;
    wr_en    = 1'b1;
    wr_addr  = 6'd3;
    wr_data  = 32'h0000_0055;
    @(posedge clk);
    #1;
    check_eq("req_enter", 64'(ready), 64'd0);
    @(negedge clk);
    init_req = 1'b0;
    wr_en    = 1'b0;
    sweep(30, 6'd3, 20, -1, n);
    check_eq("sweep1_edges", 64'(n), 64'd64);
    model_sweep();
    rd_pair("reinit1_3", 6'd1, 6'd3);
    rd_pair("reinit5_7", 6'd5, 6'd7);

    // Reset in the middle of a sweep restarts it from index 0.
    wr(6'd0, 32'h0000_0099);
    @(negedge clk);
    init_req = 1'b1;
    @(negedge clk);
    init_req = 1'b0;
    sweep(29, 6'd2, -1, 30, n);
    check_eq("sweep2_edges", 64'(n), 64'd64);
    model_sweep();
    rd_pair("rst0_2", 6'd0, 6'd2);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule : tb_regfile_mp
`default_nettype wire

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 Parameter DATA_W, default 32, SHALL set the bit width of each entry.
REQ-002 Parameter ADDR_W, default 6, SHALL set the address width; DEPTH SHALL be 2**ADDR_W.
REQ-003 Parameter NUM_RD, default 2, SHALL set the number of independent read ports (1..4).
REQ-004 Parameter INIT_CNT, default 2, SHALL set how many low entries (0..INIT_CNT-1) initialise to INIT_VAL.
REQ-005 Parameter INIT_VAL, default 32'h0000_0002, SHALL be the init value of those entries; all other entries initialise to 0.
REQ-006 clk  input  1  clock; all state SHALL change on the rising edge.
REQ-007 rst_n  input  1  reset, asynchronous, active-low.
REQ-008 init_req  input  1  one-cycle request to re-run the initialisation sweep.
REQ-009 ready  output  1  high when the init sweep is complete and writes are accepted.
REQ-010 rd_addr  input  NUM_RD*ADDR_W  read addresses, port k at bits [k*ADDR_W +: ADDR_W].
REQ-011 rd_data  output  NUM_RD*DATA_W  read data, port k at bits [k*DATA_W +: DATA_W].
REQ-012 wr_en  input  1  write strobe.
REQ-013 wr_addr  input  ADDR_W  write address.
REQ-014 wr_data  input  DATA_W  write data.
REQ-015 wr_drop  output  1  registered pulse: a write was presented while ready=0.

Function
REQ-016 FSM states SHALL be INIT and READY only; ready SHALL equal (state==READY).
REQ-017 In INIT, each clock edge SHALL write entry idx (INIT_VAL if idx<INIT_CNT else 0) and increment idx by 1.
REQ-018 On the edge that writes idx==DEPTH-1, the FSM SHALL move to READY; the sweep therefore takes exactly DEPTH cycles.
REQ-019 In READY with wr_en=1, mem[wr_addr] SHALL take wr_data on the edge; the write is visible on rd_data from the next cycle.
REQ-020 In INIT, wr_en=1 SHALL NOT modify memory and SHALL set wr_drop=1 for the following cycle; otherwise wr_drop=0.
REQ-021 Reads SHALL be combinational: rd_data[k] = mem[rd_addr[k]] in READY; rd_data SHALL be all-zero in INIT.
REQ-022 All read ports SHALL be fully independent; identical addresses on multiple ports SHALL return identical data.
REQ-023 init_req=1 in READY SHALL move to INIT with idx=0 on that edge; a write in the same cycle SHALL still be performed before the sweep overwrites it.
REQ-024 init_req in INIT SHALL be ignored (sweep neither restarts nor extends).
REQ-025 idx SHALL be ADDR_W+1 bits wide to detect completion without wrap-around.

Reset
REQ-026 rst_n low SHALL immediately force state=INIT, idx=0, ready=0, wr_drop=0, regardless of clk.
REQ-027 Memory contents SHALL NOT be asynchronously reset; defined contents are produced by the sweep only.
REQ-028 Reset asserted mid-sweep or mid-operation SHALL restart the sweep at idx=0 after deassertion.

Configuration
REQ-029 Macro REGFILE_BYPASS_EN SHALL control write-to-read forwarding.
REQ-030 With REGFILE_BYPASS_EN defined, in READY, if wr_en=1 and wr_addr==rd_addr[k], rd_data[k] SHALL equal wr_data in the same cycle.
REQ-031 Without REGFILE_BYPASS_EN, rd_data[k] SHALL show the old contents until the edge after the write.

Structure
REQ-032 Package regfile_pkg SHALL hold the state enum (INIT, READY) and the default DATA_W/ADDR_W/INIT_VAL constants.
REQ-033 The sweep counter and FSM SHALL live in sub-module regfile_init_seq, outputting idx, sweep write enable, and ready.

Verification
REQ-034 Defaults: release rst_n, count edges -> ready rises after exactly 64 edges; read 0,1,2,63 -> 0x2,0x2,0x0,0x0.
REQ-035 READY: write 0xDEADBEEF to addr 5, both ports read 5 next cycle -> 0xDEADBEEF on both.
REQ-036 With REGFILE_BYPASS_EN: same-cycle write 0x1234 to addr 7 with rd_addr[0]=7 -> rd_data[0]=0x1234 that cycle; without macro -> old value (0).
REQ-037 wr_en=1 at cycle 10 of sweep, addr 40 -> wr_drop=1 next cycle; after ready, addr 40 reads 0.
REQ-038 init_req in READY after writing 0xAA to addr 1 -> ready low for 64 cycles, init_req pulsed at sweep cycle 20 ignored, then addr 1 reads 0x2.
REQ-039 Pull rst_n low at sweep cycle 30 then release -> ready rises 64 edges after release, not earlier.
